// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the data RAM between CPU and DMA, CPU priority with a DMA starvation guard
module dram_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [31:0] ADDR_LIMIT = 32'h800,
  parameter int unsigned CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_gnt_o,
  output logic        cpu_rvalid_o,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_err_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  output logic        dma_gnt_o,
  output logic        dma_rvalid_o,
  output logic [31:0] dma_rdata_o,
  output logic        dma_err_o,
  output logic [31:0] ram_raddr_o,
  output logic        ram_re_o,
  input  logic [31:0] ram_rdata_i,
  output logic [31:0] ram_waddr_o,
  output logic        ram_we_o,
  output logic [31:0] ram_wdata_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpu_rvalid_q, cpu_rvalid_d, cpu_err_q, cpu_err_d;
  logic             dma_rvalid_q, dma_rvalid_d, dma_err_q, dma_err_d;
  logic [31:0]      cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic             dma_win, cpu_win, sel_we, sel_bad, acc;
  logic [31:0]      sel_addr, sel_wdata, rsp_data;

  // Pick the winner, validate its address and drive the RAM ports
  always_comb begin
    dma_win     = dma_req_i & (~cpu_req_i | (cnt_q == CNT_W'(STARVE_MAX)));
    cpu_win     = cpu_req_i & ~dma_win;
    sel_addr    = dma_win ? dma_addr_i : cpu_addr_i;
    sel_we      = dma_win ? dma_we_i : cpu_we_i;
    sel_wdata   = dma_win ? dma_wdata_i : cpu_wdata_i;
    sel_bad     = (sel_addr >= ADDR_LIMIT) | (sel_addr[1:0] != 2'b00);
    acc         = (cpu_win | dma_win) & ~sel_bad;
    ram_re_o    = acc & ~sel_we;
    ram_we_o    = acc & sel_we;
    ram_raddr_o = ram_re_o ? sel_addr : '0;
    ram_waddr_o = ram_we_o ? sel_addr : '0;
    ram_wdata_o = ram_we_o ? sel_wdata : '0;
    cpu_gnt_o   = cpu_win;
    dma_gnt_o   = dma_win;
  end

  // Next starvation count and next response registers; only the winner's response changes
  always_comb begin
    cnt_d        = (dma_win | ~dma_req_i) ? '0 :
                   (cpu_win && cnt_q != CNT_W'(STARVE_MAX)) ? cnt_q + 1'b1 : cnt_q;
    rsp_data     = ram_re_o ? ram_rdata_i : '0;
    cpu_rvalid_d = cpu_win;
    cpu_err_d    = cpu_win ? sel_bad : cpu_err_q;
    cpu_rdata_d  = cpu_win ? rsp_data : cpu_rdata_q;
    dma_rvalid_d = dma_win;
    dma_err_d    = dma_win ? sel_bad : dma_err_q;
    dma_rdata_d  = dma_win ? rsp_data : dma_rdata_q;
  end

  // State registers; reset drops any in-flight response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
      dma_err_q    <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_err_q    <= cpu_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_err_q    <= dma_err_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign cpu_rvalid_o = cpu_rvalid_q;
  assign cpu_err_o    = cpu_err_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign dma_rvalid_o = dma_rvalid_q;
  assign dma_err_o    = dma_err_q;
  assign dma_rdata_o  = dma_rdata_q;
endmodule
